pdm_capture_ctrl: RTL
=====================

// Module: pdm_capture_ctrl
// PURPOSE
// - Sequences one microphone recording: mic settle wait, then word-by-word capture into a sample RAM.
// - Drives the PDM deserializer's enable, restarts it after every word and writes each word to RAM.
// - Sits between the top-level record/stop controls and the deserializer + sample RAM write port.
// PARAMETERS
// - WORD_LENGTH    16         bits per deserialized word / RAM data width
// - DEPTH          1024       sample RAM depth in words (power of two, >= 2)
// - ADDR_W         $clog2(DEPTH)  RAM address width (derived, not overridden)
// - SETTLE_CYCLES  1000000    clock_i cycles to wait after start before capturing (10 ms @ 100 MHz)
// PORTS
// - clock_i      in   1            100 MHz system clock; the only clock
// - reset_i      in   1            reset, asynchronous, active-high
// - start_i      in   1            one-cycle request to begin a recording
// - stop_i       in   1            one-cycle request to end a recording early
// - deser_en_o   out  1            enable to deserializer (low = deserializer held in reset)
// - deser_done_i in   1            deserializer word-ready level
// - deser_data_i in   WORD_LENGTH  deserializer word, valid while deser_done_i high
// - mem_we_o     out  1            RAM write strobe, one cycle per word
// - mem_addr_o   out  ADDR_W       RAM write address
// - mem_data_o   out  WORD_LENGTH  RAM write data
// - busy_o       out  1            high in SETTLE, CAPTURE, RESTART
// - done_o       out  1            high in DONE
// - count_o      out  ADDR_W+1     words captured this recording, saturates at DEPTH
// - overflow_o   out  1            RAM wrapped at least once (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; deser_en_o, mem_we_o, busy_o, done_o, overflow_o = 0;
//   mem_addr_o, mem_data_o, count_o, settle counter, done-edge register = 0.
// - States: IDLE, SETTLE, CAPTURE, RESTART, DONE.
// - IDLE/DONE + start_i -> SETTLE: clear addr, count_o, overflow_o; done_o drops next cycle.
// - start_i in SETTLE/CAPTURE/RESTART is ignored. stop_i in IDLE/DONE is ignored.
// - SETTLE: deser_en_o=0; count SETTLE_CYCLES cycles, then CAPTURE. stop_i -> DONE, count_o=0.
// - CAPTURE: deser_en_o=1. A rising edge of deser_done_i (registered prev value) latches deser_data_i
//   into mem_data_o and asserts mem_we_o on the next cycle at the current mem_addr_o; same cycle
//   -> RESTART.
// - RESTART: deser_en_o=0 for exactly one cycle (clears deserializer), then CAPTURE.
//   mem_addr_o increments by 1 and count_o saturating-increments after the write cycle.
// - Latency: deser_done_i rise to mem_we_o = 1 cycle; word period = 16 enabled cycles + 1 restart.
// - Full: write to address DEPTH-1 completes -> DONE (unless wrap enabled); no write is lost or repeated.
// - stop_i same cycle as a done edge in CAPTURE: the word is written, then DONE (write wins).
// - stop_i in RESTART: pending write completes, then DONE.
// - deser_done_i held high with no new rise never produces a second write.
// - Reset mid-recording aborts; partial RAM contents are not cleared.
// CONFIGURATION
// - Macro PDM_CAPTURE_WRAP_EN defined: at full, mem_addr_o wraps DEPTH-1 -> 0, overflow_o sets
//   and holds; capture continues until stop_i; count_o saturates at DEPTH.
// - Macro undefined: no wrap; a full RAM ends the recording (-> DONE); overflow_o constant 0.
// STRUCTURE
// - Package pdm_capture_pkg: state enum capture_state_t (IDLE, SETTLE, CAPTURE, RESTART, DONE),
//   default WORD_LENGTH/DEPTH/SETTLE_CYCLES constants.
// - One sub-module: pdm_settle_timer (load/count/expire down-counter of SETTLE_CYCLES).
// - FSM, edge detect, address/count logic stay in pdm_capture_ctrl.
// TESTING (DEPTH=4, SETTLE_CYCLES=8, bench deserializer model)
// - Reset mid-CAPTURE -> all outputs 0 same cycle; after release, state IDLE, deser_en_o=0.
// - start_i pulse -> deser_en_o stays 0 for 8 cycles, rises on cycle 9; busy_o=1 throughout.
// - 4 words A1A1,B2B2,C3C3,D4D4 -> writes at addr 0..3 in order, one mem_we_o each, done_o=1,
//   count_o=4.
// - stop_i same cycle as 2nd done edge -> word 2 written at addr 1, then DONE, count_o=2.
// - deser_done_i held high 20 cycles -> exactly one write; deser_en_o low exactly 1 cycle after it.
// - PDM_CAPTURE_WRAP_EN, 6 words then stop_i -> words 5,6 at addr 0,1; overflow_o=1; count_o=4.

Source files
------------

// File: rtl/pdm_capture_pkg.sv
// ---------------------------------------------------------------------------
// pdm_capture_pkg
// Shared definitions for the PDM capture controller:
//   - capture_state_t : recording sequencer states
//   - DEF_*           : default sizing constants for the controller
// ---------------------------------------------------------------------------
package pdm_capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        RESTART = 3'd3,
        DONE    = 3'd4
    } capture_state_t;

    localparam int DEF_WORD_LENGTH   = 16;
    localparam int DEF_DEPTH         = 1024;
    localparam int DEF_SETTLE_CYCLES = 1000000;  // 10 ms at 100 MHz

endpackage

// File: rtl/pdm_settle_timer.sv
// ---------------------------------------------------------------------------
// pdm_settle_timer
// Down-counter that measures the microphone settle interval.
// Ports:
//   clock_i     in  system clock
//   reset_i     in  asynchronous active-high reset (counter -> 0)
//   load_i      in  reload the counter for a fresh SETTLE_CYCLES interval
//   count_en_i  in  count down while high
//   expired_o   out counter has reached zero
// Loading SETTLE_CYCLES-1 and expiring on zero makes expired_o true in the
// SETTLE_CYCLES-th enabled cycle, so the owner leaves its wait state after
// exactly SETTLE_CYCLES cycles.
// ---------------------------------------------------------------------------
module pdm_settle_timer
    import pdm_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= LOAD_VAL;
        end else if (count_en_i && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired_o = (r_count == '0);

endmodule

// File: rtl/pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl
// Sequences one microphone recording: settle wait, then word-by-word capture
// of deserializer output into a sample RAM.
// Ports:
//   clock_i       in  system clock (only clock)
//   reset_i       in  asynchronous active-high reset
//   start_i       in  one-cycle request to begin a recording (IDLE/DONE only)
//   stop_i        in  one-cycle request to end a recording early
//   deser_en_o    out deserializer enable (low holds it in reset)
//   deser_done_i  in  deserializer word-ready level
//   deser_data_i  in  deserializer word, valid while deser_done_i is high
//   mem_we_o      out RAM write strobe, one cycle per word
//   mem_addr_o    out RAM write address
//   mem_data_o    out RAM write data
//   busy_o        out high in SETTLE, CAPTURE, RESTART
//   done_o        out high in DONE
//   count_o       out words captured this recording, saturating at DEPTH
//   overflow_o    out RAM wrapped at least once (wrap build only, else 0)
//   dbg_state_o   out current sequencer state (debug observation)
// Build option: define PDM_CAPTURE_WRAP_EN to let a full RAM wrap to address
// 0 and keep capturing until stop_i; otherwise a full RAM ends the recording.
//
// Deserializer/RAM handshake: a word is offered by a low-to-high transition of
// deser_done_i while deser_en_o is high. The controller accepts it on that
// edge, presents it to the RAM with mem_we_o high for exactly one cycle on the
// following cycle, and drops deser_en_o during that same write cycle to clear
// the deserializer. The RAM has no back-pressure; a write always completes.
// ---------------------------------------------------------------------------
module pdm_capture_ctrl
    import pdm_capture_pkg::*;
#(
    parameter  int WORD_LENGTH   = DEF_WORD_LENGTH,
    parameter  int DEPTH         = DEF_DEPTH,
    parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    output logic                   deser_en_o,
    input  logic                   deser_done_i,
    input  logic [WORD_LENGTH-1:0] deser_data_i,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [WORD_LENGTH-1:0] mem_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ADDR_W:0]        count_o,
    output logic                   overflow_o,
    output logic [2:0]             dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    capture_state_t          r_state;
    capture_state_t          w_next_state;
    logic                    r_prev_done;
    logic                    r_we;
    logic                    r_stop_pend;   // stop arrived together with a word edge
    logic [ADDR_W-1:0]       r_addr;
    logic [WORD_LENGTH-1:0]  r_data;
    logic [ADDR_W:0]         r_count;

    logic w_rise;
    logic w_start_rec;
    logic w_latch;
    logic w_commit;
    logic w_timer_expired;
    logic w_at_last;
    logic w_full_end;

    assign w_rise    = deser_done_i & ~r_prev_done;
    assign w_at_last = (r_addr == LAST_ADDR);

    pdm_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (w_start_rec),
        .count_en_i (r_state == SETTLE),
        .expired_o  (w_timer_expired)
    );

`ifdef PDM_CAPTURE_WRAP_EN
    logic r_overflow;

    // Address wraps naturally (DEPTH is a power of two); only record that it did.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (w_start_rec) begin
            r_overflow <= 1'b0;
        end else if (w_commit && w_at_last) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;
    assign w_full_end = 1'b0;
`else
    assign overflow_o = 1'b0;
    assign w_full_end = w_at_last;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_rec  = 1'b0;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_next_state = SETTLE;
                    w_start_rec  = 1'b1;
                end
            end
            SETTLE: begin
                if (stop_i) begin
                    w_next_state = DONE;
                end else if (w_timer_expired) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                // A word edge beats a simultaneous stop; the stop is remembered.
                if (w_rise) begin
                    w_latch      = 1'b1;
                    w_next_state = RESTART;
                end else if (stop_i) begin
                    w_next_state = DONE;
                end
            end
            RESTART: begin
                // This is the RAM write cycle; advance address/count as it completes.
                w_commit = 1'b1;
                if (r_stop_pend || stop_i || w_full_end) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = CAPTURE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_prev_done <= 1'b0;
            r_we        <= 1'b0;
            r_stop_pend <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_count     <= '0;
        end else begin
            // Tracked every cycle so a level held across RESTART is not a new edge.
            r_prev_done <= deser_done_i;
            r_we        <= w_latch;
            if (w_start_rec) begin
                r_addr      <= '0;
                r_count     <= '0;
                r_stop_pend <= 1'b0;
            end
            if (w_latch) begin
                r_data      <= deser_data_i;
                r_stop_pend <= stop_i;
            end
            if (w_commit) begin
                r_addr      <= r_addr + 1'b1;
                r_stop_pend <= 1'b0;
                if (r_count != FULL_COUNT) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign deser_en_o  = (r_state == CAPTURE);
    assign busy_o      = (r_state == SETTLE) || (r_state == CAPTURE) || (r_state == RESTART);
    assign done_o      = (r_state == DONE);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign count_o     = r_count;
    assign dbg_state_o = r_state;

endmodule
